// File: rtl/bit_serial_cmp_pkg.sv
// Shared types for the bit-serial compare controller and the schedulers built on it.
package bit_serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  // One-hot bit positions of a compare result; downstream sort/min-max logic indexes by these.
  localparam int unsigned RES_LT = 0;
  localparam int unsigned RES_EQ = 1;
  localparam int unsigned RES_GT = 2;
  localparam int unsigned RES_W  = 3;

  function automatic logic [RES_W-1:0] encode_result(input logic lt, input logic eq);
    logic [RES_W-1:0] r;
    r         = '0;
    r[RES_LT] = lt;
    r[RES_EQ] = eq;
    r[RES_GT] = ~lt & ~eq;
    return r;
  endfunction

endpackage

// File: rtl/subtractor_1bit_cmp.sv
// One-bit borrow cell computing A - B - Bin; two equivalent borrow implementations.
module subtractor_1bit_cmp #(
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic bout_o
);

  assign diff_o = a_i ^ b_i ^ bin_i;

  if (IMPL_TYPE == 0) begin : g_xor_mux
    // Differing bits decide the borrow (B), equal bits propagate the incoming one.
    assign bout_o = (a_i ^ b_i) ? b_i : bin_i;
  end else begin : g_maj_not
    assign bout_o = (~a_i & b_i) | (~a_i & bin_i) | (b_i & bin_i);
  end

endmodule

// File: rtl/bit_serial_cmp_ctrl.sv
// Bit-serial magnitude comparator: streams operands LSB-first through one borrow cell.
module bit_serial_cmp_ctrl
  import bit_serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             out_eq,
  output logic             out_gt,
  output logic             busy
);

  if (WIDTH < 2) begin : g_bad_width
    $error("bit_serial_cmp_ctrl: WIDTH must be >= 2");
  end

  localparam int unsigned       CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  cmp_state_e       state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sgn_q, borrow_q, neq_q;
  logic [RES_W-1:0] res_q;
  logic             in_ready_q, out_valid_q, busy_q;

  logic is_last_d, a_bit_d, b_bit_d, diff_d, bout_d, bit_xor_d;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  assign is_last_d = (cnt_q == LAST);
  assign a_bit_d   = a_sh_q[0] ^ (sgn_q & is_last_d);
  assign b_bit_d   = b_sh_q[0] ^ (sgn_q & is_last_d);
  // a^b recovered from the cell's difference output; the sign flip cancels in the xor.
  assign bit_xor_d = diff_d ^ borrow_q;

  subtractor_1bit_cmp #(
    .IMPL_TYPE(IMPL_TYPE)
  ) u_cell (
    .a_i   (a_bit_d),
    .b_i   (b_bit_d),
    .bin_i (borrow_q),
    .diff_o(diff_d),
    .bout_o(bout_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      borrow_q    <= 1'b0;
      neq_q       <= 1'b0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q     <= in_a;
            b_sh_q     <= in_b;
            sgn_q      <= in_signed;
            borrow_q   <= 1'b0;
            neq_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          borrow_q <= bout_d;
          neq_q    <= neq_q | bit_xor_d;
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          if (is_last_d) begin
            res_q       <= encode_result(bout_d, ~(neq_q | bit_xor_d));
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_lt    = res_q[RES_LT];
  assign out_eq    = res_q[RES_EQ];
  assign out_gt    = res_q[RES_GT];

endmodule

// File: tb/tb_bit_serial_cmp_ctrl.sv
// Directed and random checks of bit_serial_cmp_ctrl; two instances (IMPL_TYPE 0 and 1) share stimulus.
module tb_bit_serial_cmp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_signed, out_ready;
  logic [7:0] in_a, in_b;
  logic       in_ready0, out_valid0, out_lt0, out_eq0, out_gt0, busy0;
  logic       in_ready1, out_valid1, out_lt1, out_eq1, out_gt1, busy1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_cmp_ctrl #(.WIDTH(8), .IMPL_TYPE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_lt(out_lt0), .out_eq(out_eq0), .out_gt(out_gt0), .busy(busy0)
  );

  bit_serial_cmp_ctrl #(.WIDTH(8), .IMPL_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_lt(out_lt1), .out_eq(out_eq1), .out_gt(out_gt1), .busy(busy1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Flags packed as {gt,eq,lt} for both instances.
  task automatic check_flags(input string tag, input logic lt, input logic eq, input logic gt);
    check({tag, "_dut0"}, int'({out_gt0, out_eq0, out_lt0}), int'({gt, eq, lt}));
    check({tag, "_dut1"}, int'({out_gt1, out_eq1, out_lt1}), int'({gt, eq, lt}));
  endtask

  task automatic check_ctrl(input string tag, input logic vld, input logic rdy, input logic bsy);
    check({tag, "_ctrl0"}, int'({out_valid0, in_ready0, busy0}), int'({vld, rdy, bsy}));
    check({tag, "_ctrl1"}, int'({out_valid1, in_ready1, busy1}), int'({vld, rdy, bsy}));
  endtask

  // Presents operands while in_ready is high; returns after the accept edge (+1).
  task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic s);
    int n;
    n = 0;
    while (!in_ready0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready_timeout", int'(n < 50), 1);
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!(out_valid0 && out_valid1) && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic lt, input logic eq, input logic gt);
    int lat;
    accept(a, b, s);
    wait_result(lat);
    check({tag, "_latency"}, lat, 8);
    check_flags(tag, lt, eq, gt);
    drain();
    check_ctrl({tag, "_after_drain"}, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    int lat;
    int unsigned r;
    logic [7:0] ra, rb;
    logic rs, elt, eeq;

    rst = 1'b1; in_valid = 1'b0; in_signed = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    #1;
    check_ctrl("reset_ctrl", 1'b0, 1'b1, 1'b0);
    check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    txn("u_05_03",     8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
    txn("u_A5_A5",     8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    txn("s_A5_A5",     8'hA5, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
    txn("u_FF_01",     8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
    txn("s_FF_01",     8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    txn("s_80_7F",     8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    txn("u_80_7F",     8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    txn("u_00_FF",     8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    txn("s_7F_80",     8'h7F, 8'h80, 1'b1, 1'b0, 1'b0, 1'b1);
    txn("u_01_00_lsb", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);

    // Flags keep their last value while idle.
    @(posedge clk); #1;
    check_flags("idle_hold", 1'b0, 1'b0, 1'b1);

    // Backpressure in DONE; operand changes after accept must not matter.
    accept(8'h10, 8'h90, 1'b1);
    in_a = 8'h00; in_b = 8'hFF; in_signed = 1'b0;
    wait_result(lat);
    check("bp_latency", lat, 8);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i != 1);
      in_a = 8'h33; in_b = 8'h22;
      @(posedge clk); #1;
      check_ctrl("bp_hold_ctrl", 1'b1, 1'b0, 1'b1);
      check_flags("bp_hold_flags", 1'b0, 1'b0, 1'b1);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check_ctrl("bp_release", 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_ctrl("bp_no_accept_in_done", 1'b0, 1'b1, 1'b0);

    // Async reset in the fourth RUN cycle discards the transaction.
    accept(8'hC3, 8'h3C, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_ctrl("midrun_reset_ctrl", 1'b0, 1'b1, 1'b0);
    check_flags("midrun_reset_flags", 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid0 || out_valid1) lat++;
    end
    check("midrun_no_valid", lat, 0);
    txn("post_reset_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random transactions against a reference compare, both instances.
    for (int i = 0; i < 1000; i++) begin
      r = $urandom;
      ra = r[7:0]; rb = r[15:8]; rs = r[16];
      if (r[20:18] == 3'd0) rb = ra;
      elt = rs ? ($signed(ra) < $signed(rb)) : (ra < rb);
      eeq = (ra == rb);
      accept(ra, rb, rs);
      wait_result(lat);
      check("rand_latency", lat, 8);
      check_flags("rand", elt, eeq, ~elt & ~eeq);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_cmp_ctrl.md
Name: bit_serial_cmp_ctrl

Overview:
Bit-serial magnitude comparator controller. It accepts two WIDTH-bit operands over a valid/ready handshake and sequences one 1-bit borrow cell (subtractor_1bit_cmp) LSB-first over WIDTH cycles. It returns lt/eq/gt flags over a second valid/ready handshake. It is the PIM-style scheduling wrapper that turns the single borrow cell into a full-width compare unit, with unsigned and signed modes selected per transaction.

Parameters:
WIDTH, 8, operand width in bits; must be >= 2, elaboration error otherwise
IMPL_TYPE, 0, passed to the borrow cell (0 = XOR+MUX, 1 = MAJ+NOT); results must be identical for both

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand transaction valid
in_ready  out  1  controller can accept operands
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_signed  in  1  1 = two's-complement compare, 0 = unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_lt  out  1  A < B
out_eq  out  1  A == B
out_gt  out  1  A > B
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, DONE. Reset (async on rst high) sets state=IDLE, cnt=0, borrow=0, neq=0, shift regs=0, out_lt/out_eq/out_gt=0, out_valid=0, in_ready=1, busy=0.
- IDLE: in_ready=1. On in_valid&in_ready:
  - a_sh<=in_a, b_sh<=in_b, sgn<=in_signed, borrow<=0, neq<=0, cnt<=0.
  - -> RUN.
- RUN: one bit per cycle, bit index = cnt.
  - Cell inputs: A=a_sh[0], B=b_sh[0], Bin=borrow.
  - When sgn=1 and cnt==WIDTH-1, both A and B are inverted (sign-bit flip maps signed order onto unsigned order).
  - borrow<=Bout; neq<=neq|(a_sh[0]^b_sh[0]); a_sh, b_sh shift right by 1; cnt<=cnt+1.
  - On the cycle processing cnt==WIDTH-1 -> DONE; result regs load:
    - out_lt = final Bout
    - out_eq = ~(neq | last-bit xor)
    - out_gt = ~out_lt & ~out_eq
  - in_ready=0 throughout. in_valid is ignored.
- DONE: out_valid=1, result flags held stable until out_valid&out_ready; then -> IDLE and out_valid=0 next cycle.
- Latency: operand accept edge to out_valid high = exactly WIDTH cycles. Minimum initiation interval = WIDTH+2 cycles (accept, WIDTH run cycles, DONE handshake, back to IDLE).
- No overlap: in_ready=0 in DONE even if out_ready=1 in that cycle. The next accept happens in IDLE.
- Exactly one of out_lt/out_eq/out_gt is 1 whenever out_valid=1. All three are 0 out of reset until the first result. Flags keep their last values in IDLE.
- cnt width = $clog2(WIDTH). It never wraps past WIDTH-1.
- Reset mid-RUN or mid-DONE: in-flight transaction is discarded with no out_valid pulse. Outputs return to reset values immediately (async).
- in_a/in_b/in_signed are sampled only at accept. Changes afterward have no effect.

Decomposition:
- Shared package bit_serial_cmp_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam for result encoding (LT/EQ/GT one-hot order) reused by downstream sort/min-max schedulers
- One sub-module: the existing subtractor_1bit_cmp cell, instantiated once with IMPL_TYPE passed through.
- Shift registers, counter and FSM stay inline.

Test Plan:
- Unsigned, in_a=8'h05, in_b=8'h03 -> out_valid exactly 8 cycles after accept, gt=1, lt=0, eq=0.
- Equal operands 8'hA5/8'hA5, unsigned, then signed -> eq=1 both times.
- 8'hFF vs 8'h01: in_signed=0 -> gt=1; in_signed=1 -> lt=1 (−1 < 1). 8'h80 vs 8'h7F signed -> lt=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid and flags stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset asserted on RUN cycle 4 -> state IDLE, out_valid never rises, flags=0. A new transaction 8'h10 vs 8'h20 afterward -> lt=1.
- Random 1000 transactions, both modes, IMPL_TYPE 0 and 1 -> flags match a reference compare and are identical across IMPL_TYPE.
